regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 60 ++++++
 tb/tb_regfile_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy scoreboard, issue stall and pending count.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     pending_cnt
);
  localparam logic [AW:0] one = 1;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic fwd1, fwd2, set, clr;
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wb_valid && wb_rd != '0 && wb_rd == rs1_addr;
  assign fwd2 = wb_valid && wb_rd != '0 && wb_rd == rs2_addr;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  always_comb begin
    rs1_data = fwd1 ? wb_data : regs[rs1_addr];
    rs2_data = fwd2 ? wb_data : regs[rs2_addr];
    rs1_busy = !fwd1 && busy[rs1_addr];
    rs2_busy = !fwd2 && busy[rs2_addr];
    stall    = issue_valid && (rs1_busy || rs2_busy || busy[issue_rd]);
    set      = issue_valid && !stall && issue_rd != '0;
    clr      = wb_valid && busy[wb_rd];
    busy_nxt = busy;
    if (clr) busy_nxt[wb_rd] = 1'b0;
    // set is applied last so it wins over a clear of the same register
    if (set) busy_nxt[issue_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wb_valid && wb_rd != '0) regs[wb_rd] <= wb_data;
      busy <= busy_nxt;
      if (set && !clr) pending_cnt <= pending_cnt + one;
      else if (clr && !set) pending_cnt <= pending_cnt - one;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized traffic checked against a behavioural model.
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] rs1_addr = '0, rs2_addr = '0, issue_rd = '0, wb_rd = '0;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data = '0;
  logic rs1_busy, rs2_busy, issue_valid = 1'b0, stall, wb_valid = 1'b0;
  logic [AW:0] pending_cnt;
  always #5 clk = ~clk;
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .pending_cnt(pending_cnt));

  int n_chk = 0, n_fail = 0;
  logic [XLEN-1:0] mreg [NREGS];
  bit mbusy [NREGS];

  typedef struct {
    logic rst, iv; logic [AW-1:0] ird, r1, r2; logic wbv; logic [AW-1:0] wrd; logic [XLEN-1:0] wdat;
    logic stall; logic [XLEN-1:0] d1; logic b1; logic [XLEN-1:0] d2; logic b2; int pc;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t v(logic r, logic iv, int ird, int r1, int r2, logic wbv, int wrd,
                             logic [XLEN-1:0] wdat, logic st, logic [XLEN-1:0] d1, logic b1,
                             logic [XLEN-1:0] d2, logic b2, int pc);
    vec_t x;
    x.rst = r; x.iv = iv; x.ird = AW'(ird); x.r1 = AW'(r1); x.r2 = AW'(r2);
    x.wbv = wbv; x.wrd = AW'(wrd); x.wdat = wdat;
    x.stall = st; x.d1 = d1; x.b1 = b1; x.d2 = d2; x.b2 = b2; x.pc = pc;
    return x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_fwd(logic [AW-1:0] a);
    return BYP && wb_valid && wb_rd != 0 && wb_rd == a;
  endfunction
  function automatic logic [XLEN-1:0] m_data(logic [AW-1:0] a);
    return m_fwd(a) ? wb_data : (a == 0 ? '0 : mreg[a]);
  endfunction
  function automatic bit m_busy(logic [AW-1:0] a);
    return m_fwd(a) ? 1'b0 : mbusy[a];
  endfunction
  function automatic bit m_stall();
    return issue_valid && (m_busy(rs1_addr) || m_busy(rs2_addr) || mbusy[issue_rd]);
  endfunction
  function automatic int m_count();
    int c = 0;
    foreach (mbusy[i]) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic apply(input vec_t x);
    rst = x.rst; issue_valid = x.iv; issue_rd = x.ird; rs1_addr = x.r1; rs2_addr = x.r2;
    wb_valid = x.wbv; wb_rd = x.wrd; wb_data = x.wdat;
    #2;
  endtask

  task automatic model_check();
    check("stall", 64'(stall), 64'(m_stall()));
    check("rs1_data", 64'(rs1_data), 64'(m_data(rs1_addr)));
    check("rs2_data", 64'(rs2_data), 64'(m_data(rs2_addr)));
    check("rs1_busy", 64'(rs1_busy), 64'(m_busy(rs1_addr)));
    check("rs2_busy", 64'(rs2_busy), 64'(m_busy(rs2_addr)));
    check("pending_cnt", 64'(pending_cnt), 64'(m_count()));
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (rst) begin
      foreach (mreg[i]) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      if (wb_valid) begin
        mbusy[wb_rd] = 1'b0;
        if (wb_rd != 0) mreg[wb_rd] = wb_data;
      end
      if (issue_valid && !st && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  initial begin
    vec_t x;
    x = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(x);
    tick();
    for (int a = 0; a < NREGS; a++) begin
      x = v(0, 0, 0, a, NREGS - 1 - a, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(x);
      check("reset_rs1_zero", 64'(rs1_data), 64'd0);
      check("reset_rs2_zero", 64'(rs2_data), 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_pending", 64'(pending_cnt), 64'd0);
      tick();
    end
    //               rst iv ird r1 r2 wbv wrd wdat          stall     d1           b1        d2           b2        pc
    tbl.push_back(v(0, 0, 0,  0, 31, 0, 0,  0,            0,        0,           0,        0,           0,        0));
    tbl.push_back(v(0, 0, 0,  17, 5, 0, 0,  0,            0,        0,           0,        0,           0,        0));
    tbl.push_back(v(0, 1, 5,  0,  0, 0, 0,  0,            0,        0,           0,        0,           0,        0));
    tbl.push_back(v(0, 1, 6,  5,  0, 0, 0,  0,            1,        0,           1,        0,           0,        1));
    tbl.push_back(v(0, 0, 0,  5,  0, 1, 5,  42,           0,        BYP ? 42 : 0, !BYP,    0,           0,        1));
    tbl.push_back(v(0, 1, 6,  5,  0, 0, 0,  0,            0,        42,          0,        0,           0,        0));
    tbl.push_back(v(0, 1, 10, 0,  0, 0, 0,  0,            0,        0,           0,        0,           0,        1));
    tbl.push_back(v(0, 1, 0,  0, 10, 1, 10, 84,           !BYP,     0,           0,        BYP ? 84 : 0, !BYP,    2));
    tbl.push_back(v(0, 1, 0,  0, 10, 0, 0,  0,            0,        0,           0,        84,          0,        1));
    tbl.push_back(v(0, 1, 0,  0,  0, 1, 0,  32'hFFFFFFFF, 0,        0,           0,        0,           0,        1));
    tbl.push_back(v(0, 0, 0,  0,  0, 0, 0,  0,            0,        0,           0,        0,           0,        1));
    tbl.push_back(v(0, 1, 3,  0,  0, 0, 0,  0,            0,        0,           0,        0,           0,        1));
    tbl.push_back(v(0, 1, 3,  0,  0, 0, 0,  0,            1,        0,           0,        0,           0,        2));
    tbl.push_back(v(0, 0, 0,  3,  0, 0, 0,  0,            0,        0,           1,        0,           0,        2));
    tbl.push_back(v(0, 1, 7,  7,  0, 1, 7,  99,           0,        BYP ? 99 : 0, 0,       0,           0,        2));
    tbl.push_back(v(0, 0, 0,  7,  0, 0, 0,  0,            0,        99,          1,        0,           0,        3));
    tbl.push_back(v(1, 0, 0,  3,  0, 1, 3,  55,           0,        BYP ? 55 : 0, !BYP,    0,           0,        3));
    tbl.push_back(v(0, 1, 0,  3,  7, 0, 0,  0,            0,        0,           0,        0,           0,        0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].stall));
      check($sformatf("vec%0d_rs1_data", i), 64'(rs1_data), 64'(tbl[i].d1));
      check($sformatf("vec%0d_rs1_busy", i), 64'(rs1_busy), 64'(tbl[i].b1));
      check($sformatf("vec%0d_rs2_data", i), 64'(rs2_data), 64'(tbl[i].d2));
      check($sformatf("vec%0d_rs2_busy", i), 64'(rs2_busy), 64'(tbl[i].b2));
      check($sformatf("vec%0d_pending", i), 64'(pending_cnt), 64'(tbl[i].pc));
      model_check();
      tick();
    end
    for (int c = 0; c < 600; c++) begin
      int hi;
      hi = ($urandom_range(0, 9) == 0) ? NREGS - 1 : 7;
      x = v($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, hi),
            $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, 2) == 0,
            $urandom_range(0, hi), $urandom, 0, 0, 0, 0, 0, 0);
      apply(x);
      model_check();
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
